// File: rtl/alu_exec.sv
// RV32I integer execution unit: one issued op per cycle, registered result on the exc_* bus.
// Op encodings and default widths live in alu_exec_pkg; the issuing RS must use the same package.
package alu_exec_pkg;
    localparam int unsigned OP_LOG_DEF  = 6;
    localparam int unsigned ROB_LOG_DEF = 4;

    localparam logic [OP_LOG_DEF-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_LOG_DEF-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_LOG_DEF-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_LOG_DEF-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_LOG_DEF-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_LOG_DEF-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_LOG_DEF-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_LOG_DEF-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_LOG_DEF-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_LOG_DEF-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_LOG_DEF-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_LOG_DEF-1:0] OP_ADDI  = 6'd11;
    localparam logic [OP_LOG_DEF-1:0] OP_SLTI  = 6'd12;
    localparam logic [OP_LOG_DEF-1:0] OP_SLTIU = 6'd13;
    localparam logic [OP_LOG_DEF-1:0] OP_XORI  = 6'd14;
    localparam logic [OP_LOG_DEF-1:0] OP_ORI   = 6'd15;
    localparam logic [OP_LOG_DEF-1:0] OP_ANDI  = 6'd16;
    localparam logic [OP_LOG_DEF-1:0] OP_SLLI  = 6'd17;
    localparam logic [OP_LOG_DEF-1:0] OP_SRLI  = 6'd18;
    localparam logic [OP_LOG_DEF-1:0] OP_SRAI  = 6'd19;
    localparam logic [OP_LOG_DEF-1:0] OP_ADD   = 6'd20;
    localparam logic [OP_LOG_DEF-1:0] OP_SUB   = 6'd21;
    localparam logic [OP_LOG_DEF-1:0] OP_SLL   = 6'd22;
    localparam logic [OP_LOG_DEF-1:0] OP_SLT   = 6'd23;
    localparam logic [OP_LOG_DEF-1:0] OP_SLTU  = 6'd24;
    localparam logic [OP_LOG_DEF-1:0] OP_XOR   = 6'd25;
    localparam logic [OP_LOG_DEF-1:0] OP_SRL   = 6'd26;
    localparam logic [OP_LOG_DEF-1:0] OP_SRA   = 6'd27;
    localparam logic [OP_LOG_DEF-1:0] OP_OR    = 6'd28;
    localparam logic [OP_LOG_DEF-1:0] OP_AND   = 6'd29;
endpackage

module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int unsigned OP_LOG  = OP_LOG_DEF,
    parameter int unsigned ROB_LOG = ROB_LOG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               jump_flag,
    input  logic               FU_enable,
    input  logic [OP_LOG-1:0]  FU_op,
    input  logic [31:0]        FU_Vj,
    input  logic [31:0]        FU_Vk,
    input  logic [31:0]        FU_Imm,
    input  logic [ROB_LOG-1:0] FU_DestRob,
    input  logic [31:0]        FU_CurPC,
    output logic               exc_valid,
    output logic [ROB_LOG-1:0] exc_RobId,
    output logic [31:0]        exc_value,
    output logic               exc_jump,
    output logic [31:0]        exc_target
);

    logic               r_valid;
    logic [ROB_LOG-1:0] r_rob;
    logic [31:0]        r_value;
    logic               r_jump;
    logic [31:0]        r_target;

    logic        w_is_imm;
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_pc4;
    logic [31:0] w_pcimm;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_value;
    logic        w_jump;
    logic [31:0] w_target;

    assign w_is_imm   = FU_op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                      OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    assign w_b        = w_is_imm ? FU_Imm : FU_Vk;
    assign w_shamt    = w_b[4:0];
    assign w_pc4      = FU_CurPC + 32'd4;
    assign w_pcimm    = FU_CurPC + FU_Imm;
    assign w_jalr_sum = FU_Vj + FU_Imm;

    // Result, control-transfer decision and next PC for the op being issued.
    always_comb begin
        w_value  = 32'd0;
        w_jump   = 1'b0;
        w_target = w_pc4;
        case (FU_op)
            OP_ADD,  OP_ADDI:  w_value = FU_Vj + w_b;
            OP_SUB:            w_value = FU_Vj - w_b;
            OP_SLL,  OP_SLLI:  w_value = FU_Vj << w_shamt;
            OP_SRL,  OP_SRLI:  w_value = FU_Vj >> w_shamt;
            OP_SRA,  OP_SRAI:  w_value = 32'($signed(FU_Vj) >>> w_shamt);
            OP_SLT,  OP_SLTI:  w_value = {31'd0, $signed(FU_Vj) < $signed(w_b)};
            OP_SLTU, OP_SLTIU: w_value = {31'd0, FU_Vj < w_b};
            OP_XOR,  OP_XORI:  w_value = FU_Vj ^ w_b;
            OP_OR,   OP_ORI:   w_value = FU_Vj | w_b;
            OP_AND,  OP_ANDI:  w_value = FU_Vj & w_b;
            OP_LUI:            w_value = FU_Imm;
            OP_AUIPC:          w_value = w_pcimm;
            OP_JAL: begin
                w_value = w_pc4;
                w_jump  = 1'b1;
            end
            OP_JALR: begin
                w_value  = w_pc4;
                w_jump   = 1'b1;
                w_target = {w_jalr_sum[31:1], 1'b0};
            end
            OP_BEQ:  w_jump = (FU_Vj == FU_Vk);
            OP_BNE:  w_jump = (FU_Vj != FU_Vk);
            OP_BLT:  w_jump = ($signed(FU_Vj) < $signed(FU_Vk));
            OP_BGE:  w_jump = ($signed(FU_Vj) >= $signed(FU_Vk));
            OP_BLTU: w_jump = (FU_Vj < FU_Vk);
            OP_BGEU: w_jump = (FU_Vj >= FU_Vk);
            default: w_value = 32'd0;
        endcase
        // JAL and taken branches are PC-relative; JALR already set its own target.
        if (w_jump && (FU_op != OP_JALR)) begin
            w_target = w_pcimm;
        end
    end

    // Single result stage; flush clears everything and drops a same-cycle issue.
    always_ff @(posedge clk) begin
        if (rst || jump_flag) begin
            r_valid  <= 1'b0;
            r_rob    <= '0;
            r_value  <= 32'd0;
            r_jump   <= 1'b0;
            r_target <= 32'd0;
        end else if (rdy) begin
            r_valid <= FU_enable;
            if (FU_enable) begin
                r_rob    <= FU_DestRob;
                r_value  <= w_value;
                r_jump   <= w_jump;
                r_target <= w_target;
            end
        end
    end

    assign exc_valid  = r_valid;
    assign exc_RobId  = r_rob;
    assign exc_value  = r_value;
    assign exc_jump   = r_jump;
    assign exc_target = r_target;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: expected results queued at issue, popped when the broadcast appears.
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int unsigned RW = ROB_LOG_DEF;

    typedef struct {
        logic [5:0]    op;
        logic [31:0]   vj, vk, imm;
        logic [RW-1:0] rob;
        logic [31:0]   pc, value;
        logic          jump;
        logic [31:0]   target;
    } vec_t;

    typedef struct {
        logic [RW-1:0] rob;
        logic [31:0]   value;
        logic          jump;
        logic [31:0]   target;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, rdy, jump_flag, FU_enable;
    logic [5:0]    FU_op;
    logic [31:0]   FU_Vj, FU_Vk, FU_Imm, FU_CurPC;
    logic [RW-1:0] FU_DestRob;
    logic          exc_valid, exc_jump;
    logic [RW-1:0] exc_RobId;
    logic [31:0]   exc_value, exc_target;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
        .FU_enable(FU_enable), .FU_op(FU_op), .FU_Vj(FU_Vj), .FU_Vk(FU_Vk),
        .FU_Imm(FU_Imm), .FU_DestRob(FU_DestRob), .FU_CurPC(FU_CurPC),
        .exc_valid(exc_valid), .exc_RobId(exc_RobId), .exc_value(exc_value),
        .exc_jump(exc_jump), .exc_target(exc_target)
    );

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                input logic [31:0] imm, input logic [RW-1:0] rob, input logic [31:0] pc,
                                input logic [31:0] value, input logic jump, input logic [31:0] target);
        vec_t v;
        v.op = op; v.vj = vj; v.vk = vk; v.imm = imm; v.rob = rob; v.pc = pc;
        v.value = value; v.jump = jump; v.target = target;
        return v;
    endfunction

    // Reference behaviour for the randomized subset of ops.
    function automatic vec_t model(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                   input logic [31:0] imm, input logic [RW-1:0] rob, input logic [31:0] pc);
        logic [31:0] val;
        logic        j;
        val = 32'd0;
        j   = 1'b0;
        case (op)
            OP_ADD:  val = vj + vk;
            OP_SUB:  val = vj - vk;
            OP_XOR:  val = vj ^ vk;
            OP_OR:   val = vj | vk;
            OP_AND:  val = vj & vk;
            OP_SLT:  val = ($signed(vj) < $signed(vk)) ? 32'd1 : 32'd0;
            OP_SLTU: val = (vj < vk) ? 32'd1 : 32'd0;
            OP_BEQ:  j = (vj == vk);
            OP_BNE:  j = (vj != vk);
            OP_BGE:  j = !($signed(vj) < $signed(vk));
            OP_BLTU: j = (vj < vk);
            default: val = 32'd0;
        endcase
        return mk(op, vj, vk, imm, rob, pc, val, j, j ? pc + imm : pc + 32'd4);
    endfunction

    task automatic drive(input vec_t v);
        FU_enable  = 1'b1;
        FU_op      = v.op;
        FU_Vj      = v.vj;
        FU_Vk      = v.vk;
        FU_Imm     = v.imm;
        FU_DestRob = v.rob;
        FU_CurPC   = v.pc;
    endtask

    task automatic issue(input vec_t v);
        exp_t e;
        drive(v);
        e.rob = v.rob; e.value = v.value; e.jump = v.jump; e.target = v.target;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        FU_enable = 1'b0;
        FU_op     = OP_NOP;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; jump_flag = 1'b0;
        drive(mk(OP_ADD, 32'd1, 32'd2, 32'd0, 4'd9, 32'h10, 32'd0, 1'b0, 32'd0));
        repeat (2) @(negedge clk);
        n_checks++;
        if (exc_valid !== 1'b0 || exc_RobId !== 4'd0 || exc_value !== 32'd0 ||
            exc_jump !== 1'b0 || exc_target !== 32'd0) begin
            n_err++;
            $display("FAIL reset: got v=%b rob=%0d val=%h j=%b tgt=%h, want all zero",
                     exc_valid, exc_RobId, exc_value, exc_jump, exc_target);
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        n_checks++;
        if (exc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: got valid=%b, want 0", exc_valid);
        end
    endtask

    task automatic test_alu();
        vec_t s[$];
        exp_t e;
        s.push_back(mk(OP_ADD,   32'd7,        32'hFFFFFFFF, 32'd0,        4'd3,  32'h0,        32'd6,        1'b0, 32'h4));
        s.push_back(mk(OP_SRA,   32'h80000000, 32'h24,       32'd0,        4'd1,  32'h200,      32'hF8000000, 1'b0, 32'h204));
        s.push_back(mk(OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'd0,        4'd2,  32'h204,      32'd1,        1'b0, 32'h208));
        s.push_back(mk(OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        4'd3,  32'h208,      32'd0,        1'b0, 32'h20C));
        s.push_back(mk(OP_SUB,   32'd5,        32'd7,        32'd0,        4'd4,  32'h20C,      32'hFFFFFFFE, 1'b0, 32'h210));
        s.push_back(mk(OP_SLL,   32'd1,        32'h3F,       32'd0,        4'd5,  32'h210,      32'h80000000, 1'b0, 32'h214));
        s.push_back(mk(OP_SRL,   32'hFFFFFFFF, 32'h20,       32'd0,        4'd6,  32'h214,      32'hFFFFFFFF, 1'b0, 32'h218));
        s.push_back(mk(OP_ADDI,  32'd10,       32'h99,       32'hFFFFFFFD, 4'd7,  32'h218,      32'd7,        1'b0, 32'h21C));
        s.push_back(mk(OP_SLLI,  32'd3,        32'd0,        32'h21,       4'd8,  32'h21C,      32'd6,        1'b0, 32'h220));
        s.push_back(mk(OP_SRLI,  32'h80000000, 32'd0,        32'd31,       4'd9,  32'h220,      32'd1,        1'b0, 32'h224));
        s.push_back(mk(OP_SRAI,  32'h80000000, 32'd0,        32'd31,       4'd10, 32'h224,      32'hFFFFFFFF, 1'b0, 32'h228));
        s.push_back(mk(OP_SLTI,  32'hFFFFFFFF, 32'd5,        32'd0,        4'd11, 32'h228,      32'd1,        1'b0, 32'h22C));
        s.push_back(mk(OP_SLTIU, 32'hFFFFFFFF, 32'd5,        32'd0,        4'd12, 32'h22C,      32'd0,        1'b0, 32'h230));
        s.push_back(mk(OP_XORI,  32'h0000F0F0, 32'd0,        32'hFFFFFFFF, 4'd13, 32'h230,      32'hFFFF0F0F, 1'b0, 32'h234));
        s.push_back(mk(OP_ANDI,  32'h1234,     32'hFFFF,     32'hFF,       4'd14, 32'h234,      32'h34,       1'b0, 32'h238));
        s.push_back(mk(OP_ORI,   32'h1200,     32'd0,        32'h34,       4'd15, 32'h238,      32'h1234,     1'b0, 32'h23C));
        s.push_back(mk(OP_LUI,   32'h5,        32'h55,       32'hABCDE000, 4'd0,  32'h23C,      32'hABCDE000, 1'b0, 32'h240));
        s.push_back(mk(OP_AUIPC, 32'd0,        32'd0,        32'h2000,     4'd1,  32'hFFFFF000, 32'h1000,     1'b0, 32'hFFFFF004));
        foreach (s[i]) begin
            issue(s[i]);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL alu[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
                    exc_jump !== e.jump || exc_target !== e.target) begin
                    n_err++;
                    $display("FAIL alu[%0d]: got v=%b rob=%0d val=%h j=%b tgt=%h, want v=1 rob=%0d val=%h j=%b tgt=%h",
                             i, exc_valid, exc_RobId, exc_value, exc_jump, exc_target,
                             e.rob, e.value, e.jump, e.target);
                end
            end
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (exc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL alu_drop: got valid=%b, want 0", exc_valid);
        end
    endtask

    task automatic test_branch_jump();
        vec_t s[$];
        exp_t e;
        s.push_back(mk(OP_BLT,  32'hFFFFFFFF, 32'd1, 32'h20, 4'd2, 32'h100,      32'd0,  1'b1, 32'h120));
        s.push_back(mk(OP_BGEU, 32'hFFFFFFFF, 32'd1, 32'h20, 4'd3, 32'h100,      32'd0,  1'b1, 32'h120));
        s.push_back(mk(OP_BLTU, 32'hFFFFFFFF, 32'd1, 32'h20, 4'd4, 32'h100,      32'd0,  1'b0, 32'h104));
        s.push_back(mk(OP_BGE,  32'hFFFFFFFF, 32'd1, 32'h20, 4'd5, 32'h100,      32'd0,  1'b0, 32'h104));
        s.push_back(mk(OP_BEQ,  32'd5,        32'd5, 32'h20, 4'd6, 32'h100,      32'd0,  1'b1, 32'h120));
        s.push_back(mk(OP_BNE,  32'd5,        32'd5, 32'h20, 4'd7, 32'h100,      32'd0,  1'b0, 32'h104));
        s.push_back(mk(OP_JALR, 32'h1001,     32'd0, 32'd2,  4'd5, 32'h40,       32'h44, 1'b1, 32'h1002));
        s.push_back(mk(OP_JAL,  32'd0,        32'd0, 32'd8,  4'd8, 32'hFFFFFFFC, 32'd0,  1'b1, 32'h4));
        s.push_back(mk(OP_BEQ,  32'd1,        32'd2, 32'd0,  4'd9, 32'hFFFFFFFC, 32'd0,  1'b0, 32'h0));
        s.push_back(mk(6'h3F,   32'd9,        32'd9, 32'd9,  4'd10, 32'h300,     32'd0,  1'b0, 32'h304));
        foreach (s[i]) begin
            issue(s[i]);
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL branch[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
                    exc_jump !== e.jump || exc_target !== e.target) begin
                    n_err++;
                    $display("FAIL branch[%0d]: got v=%b rob=%0d val=%h j=%b tgt=%h, want v=1 rob=%0d val=%h j=%b tgt=%h",
                             i, exc_valid, exc_RobId, exc_value, exc_jump, exc_target,
                             e.rob, e.value, e.jump, e.target);
                end
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0]  ops [11];
        logic [31:0] vj, vk;
        exp_t        e;
        ops = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLT, OP_SLTU,
                OP_BEQ, OP_BNE, OP_BGE, OP_BLTU};
        for (int i = 0; i < 40; i++) begin
            vj = $urandom();
            vk = ($urandom_range(3) == 0) ? vj : $urandom();
            issue(model(ops[$urandom_range(10)], vj, vk, {$urandom_range(255), 2'b00},
                        RW'(i), {$urandom(), 2'b00} >> 2));
            @(negedge clk);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL random[%0d]: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
                    exc_jump !== e.jump || exc_target !== e.target) begin
                    n_err++;
                    $display("FAIL random[%0d]: op=%0d vj=%h vk=%h got v=%b rob=%0d val=%h j=%b tgt=%h, want rob=%0d val=%h j=%b tgt=%h",
                             i, FU_op, FU_Vj, FU_Vk, exc_valid, exc_RobId, exc_value, exc_jump,
                             exc_target, e.rob, e.value, e.jump, e.target);
                end
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(mk(OP_ADDI, 32'd1, 32'h77, 32'd1, 4'd1, 32'h700, 32'd2, 1'b0, 32'h704));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) issue(mk(OP_ADDI, 32'd2, 32'h77, 32'd2, 4'd2, 32'h704, 32'd4, 1'b0, 32'h708));
            else begin
                jump_flag = 1'b1;
                drive(mk(OP_ADDI, 32'd3, 32'd0, 32'd3, 4'd3, 32'h708, 32'd0, 1'b0, 32'd0));
            end
            n_checks++;
            e = exp_q.pop_front();
            if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
                exc_jump !== e.jump || exc_target !== e.target) begin
                n_err++;
                $display("FAIL b2b[%0d]: got v=%b rob=%0d val=%h tgt=%h, want v=1 rob=%0d val=%h tgt=%h",
                         i, exc_valid, exc_RobId, exc_value, exc_target, e.rob, e.value, e.target);
            end
        end
        @(negedge clk);
        jump_flag = 1'b0;
        idle();
        n_checks++;
        if (exc_valid !== 1'b0 || exc_RobId !== 4'd0 || exc_value !== 32'd0 ||
            exc_jump !== 1'b0 || exc_target !== 32'd0) begin
            n_err++;
            $display("FAIL flush: got v=%b rob=%0d val=%h j=%b tgt=%h, want all zero",
                     exc_valid, exc_RobId, exc_value, exc_jump, exc_target);
        end
        @(negedge clk);
        n_checks++;
        if (exc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drop: got valid=%b rob=%0d, want valid 0", exc_valid, exc_RobId);
        end
    endtask

    task automatic test_stall_reset();
        exp_t e;
        issue(mk(OP_ADD, 32'd100, 32'd23, 32'd0, 4'd7, 32'h500, 32'd123, 1'b0, 32'h504));
        @(negedge clk);
        e = exp_q.pop_front();
        rdy = 1'b0;
        drive(mk(OP_JAL, 32'd0, 32'd0, 32'h40, 4'd8, 32'h800, 32'd0, 1'b0, 32'd0));
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
                exc_jump !== e.jump || exc_target !== e.target) begin
                n_err++;
                $display("FAIL stall[%0d]: got v=%b rob=%0d val=%h j=%b tgt=%h, want v=1 rob=%0d val=%h j=%b tgt=%h",
                         i, exc_valid, exc_RobId, exc_value, exc_jump, exc_target,
                         e.rob, e.value, e.jump, e.target);
            end
            @(negedge clk);
        end
        rdy = 1'b1;
        idle();
        @(negedge clk);
        n_checks++;
        if (exc_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got valid=%b, want 0", exc_valid);
        end
        issue(mk(OP_JAL, 32'd0, 32'd0, 32'h10, 4'd9, 32'h600, 32'h604, 1'b1, 32'h610));
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (exc_valid !== 1'b1 || exc_RobId !== e.rob || exc_value !== e.value ||
            exc_jump !== e.jump || exc_target !== e.target) begin
            n_err++;
            $display("FAIL pre_rst: got v=%b rob=%0d val=%h j=%b tgt=%h, want v=1 rob=%0d val=%h j=%b tgt=%h",
                     exc_valid, exc_RobId, exc_value, exc_jump, exc_target,
                     e.rob, e.value, e.jump, e.target);
        end
        rst = 1'b1;
        drive(mk(OP_ADD, 32'd1, 32'd1, 32'd0, 4'd4, 32'h900, 32'd0, 1'b0, 32'd0));
        @(negedge clk);
        rst = 1'b0;
        idle();
        n_checks++;
        if (exc_valid !== 1'b0 || exc_RobId !== 4'd0 || exc_value !== 32'd0 ||
            exc_jump !== 1'b0 || exc_target !== 32'd0) begin
            n_err++;
            $display("FAIL mid_rst: got v=%b rob=%0d val=%h j=%b tgt=%h, want all zero",
                     exc_valid, exc_RobId, exc_value, exc_jump, exc_target);
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        FU_Vj = 32'd0; FU_Vk = 32'd0; FU_Imm = 32'd0; FU_DestRob = '0; FU_CurPC = 32'd0;
        test_reset();
        test_alu();
        test_branch_jump();
        test_random();
        test_back_to_back();
        test_stall_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
